// File: rtl/control_sequencer.sv
// Six-state T-state control sequencer for the 4-bit accumulator datapath.
// Decodes the opcode into bus/latch strobes, with run/single-step control and a latched halt.
module control_sequencer (
    input  logic       main_clock_i,
    input  logic       clear_i,
    input  logic [3:0] opcode_i,
    input  logic       run_i,
    input  logic       step_i,
    output logic       enable_pc_o,
    output logic       latch_mar_o,
    output logic       pc_increment_o,
    output logic       enable_ram_o,
    output logic       latch_ir_o,
    output logic       enable_ir_o,
    output logic       latch_a_o,
    output logic       enable_a_o,
    output logic       clear_a_o,
    output logic       latch_b_o,
    output logic       enable_alu_o,
    output logic       sub_o,
    output logic       latch_out_o,
    output logic       halted_o,
    output logic [2:0] t_state_o
);

    typedef enum logic [2:0] {
        T1 = 3'd0,
        T2 = 3'd1,
        T3 = 3'd2,
        T4 = 3'd3,
        T5 = 3'd4,
        T6 = 3'd5
    } t_state_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_CLA = 4'b0011,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic enable_pc;
        logic latch_mar;
        logic pc_increment;
        logic enable_ram;
        logic latch_ir;
        logic enable_ir;
        logic latch_a;
        logic enable_a;
        logic clear_a;
        logic latch_b;
        logic enable_alu;
        logic sub;
        logic latch_out;
    } strobes_t;

    t_state_e state_q, state_d;
    logic     halted_q, halted_d;
    logic     step_prev_q;
    logic     adv;
    strobes_t decoded;
    strobes_t strobes;

    assign adv = !halted_q && (run_i || (step_i && !step_prev_q));

    // NOTE: Clear is synchronous, so it lives inside the clocked block; state uses <= only.
    always_ff @(posedge main_clock_i) begin
        if (clear_i) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
        step_prev_q <= step_i;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (adv) begin
            if (state_q == T4 && opcode_e'(opcode_i) == OP_HLT) begin
                halted_d = 1'b1;
                state_d  = T5;
            end else if (state_q == T6) begin
                state_d = T1;
            end else begin
                state_d = t_state_e'(state_q + 3'd1);
            end
        end
    end

    always_comb begin
        decoded = '0;
        case (state_q)
            T1: begin
                decoded.enable_pc = 1'b1;
                decoded.latch_mar = 1'b1;
            end
            T2: decoded.pc_increment = 1'b1;
            T3: begin
                decoded.enable_ram = 1'b1;
                decoded.latch_ir   = 1'b1;
            end
            T4: begin
                case (opcode_e'(opcode_i))
                    OP_LDA, OP_ADD, OP_SUB: begin
                        decoded.enable_ir = 1'b1;
                        decoded.latch_mar = 1'b1;
                    end
                    OP_CLA: decoded.clear_a = 1'b1;
                    OP_OUT: begin
                        decoded.enable_a  = 1'b1;
                        decoded.latch_out = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode_e'(opcode_i))
                    OP_LDA: begin
                        decoded.enable_ram = 1'b1;
                        decoded.latch_a    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        decoded.enable_ram = 1'b1;
                        decoded.latch_b    = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (opcode_e'(opcode_i) == OP_ADD || opcode_e'(opcode_i) == OP_SUB) begin
                    decoded.enable_alu = 1'b1;
                    decoded.latch_a    = 1'b1;
                    decoded.sub        = (opcode_e'(opcode_i) == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    // In single-step mode strobes fire only in the advancing cycle, so each latch captures once.
    always_comb begin
        strobes = decoded;
        if (clear_i) begin
            strobes         = '0;
            strobes.clear_a = 1'b1;
        end else if (!run_i && !adv) begin
            strobes = '0;
        end
    end

    assign enable_pc_o    = strobes.enable_pc;
    assign latch_mar_o    = strobes.latch_mar;
    assign pc_increment_o = strobes.pc_increment;
    assign enable_ram_o   = strobes.enable_ram;
    assign latch_ir_o     = strobes.latch_ir;
    assign enable_ir_o    = strobes.enable_ir;
    assign latch_a_o      = strobes.latch_a;
    assign enable_a_o     = strobes.enable_a;
    assign clear_a_o      = strobes.clear_a;
    assign latch_b_o      = strobes.latch_b;
    assign enable_alu_o   = strobes.enable_alu;
    assign sub_o          = strobes.sub;
    assign latch_out_o    = strobes.latch_out;
    assign halted_o       = halted_q;
    assign t_state_o      = state_q;

endmodule
